// File: rtl/imem_load_arbiter.sv
// Instruction memory arbiter: the fetch port reads, and each loader word is written as four little-endian byte writes.
// Latency: ld_done pulses 5 cycles after the acceptance edge, and the loader gets 1 word per 6 cycles.
// Backpressure: ld_ready is high only in IDLE, and cpu_stall holds IF/ID during byte writes. IMEM_ARB_STALL_CNT_EN adds stall_cycles.
module imem_load_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int BYTE_SIZE  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [31:0]           fetch_data,
  output logic                  cpu_stall,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wd,
`ifdef IMEM_ARB_STALL_CNT_EN
  output logic [15:0]           stall_cycles,
`endif
  input  logic [31:0]           mem_rd
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic [1:0] LAST_BYTE = 2'(BYTE_SIZE - 1);

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           data_q, data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 2'd0;
      base_q     <= '0;
      data_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      base_q     <= base_d;
      data_q     <= data_d;
    end
  end

  // Fetch data always comes straight from the array. During WRITE, the stall makes it irrelevant.
  assign fetch_data = mem_rd;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    base_d     = base_q;
    data_d     = data_q;
    ld_ready   = 1'b0;
    ld_done    = 1'b0;
    mem_we     = 1'b0;
    mem_wd     = 8'd0;
    mem_addr   = fetch_addr;
    cpu_stall  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The loader is not accepted while reset is held.
        ld_ready = !reset;
        if (ld_valid && !reset) begin
          base_d     = ld_addr;
          data_d     = ld_data;
          byte_cnt_d = 2'd0;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we     = 1'b1;
        mem_addr   = base_q + ADDR_WIDTH'(byte_cnt_q);
        mem_wd     = data_q[{byte_cnt_q, 3'b000} +: 8];
        cpu_stall  = fetch_req;
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == LAST_BYTE) begin
          byte_cnt_d = 2'd0;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        // This cycle guarantees fetch a slot between back-to-back loads.
        ld_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef IMEM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Scoreboard bench for imem_load_arbiter. Expected byte writes and ld_done cycles are queued by the stimulus and popped by a monitor.
module tb_imem_load_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [11:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        cpu_stall;
  logic        ld_valid;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wd;
  logic [31:0] mem_rd;
`ifdef IMEM_ARB_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  imem_load_arbiter #(.ADDR_WIDTH(12), .BYTE_SIZE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .cpu_stall  (cpu_stall),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
`ifdef IMEM_ARB_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [19:0] wr_q[$];   // {addr, byte}
  int          done_q[$]; // cycle at which ld_done is due

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [7:0] b);
    wr_q.push_back({a, b});
  endtask

  // Monitor: pops expected writes and ld_done cycles whenever the DUT presents them.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", {12'd0, mem_addr, mem_wd}, 32'hFFFFFFFF);
        end else begin
          logic [19:0] e;
          e = wr_q.pop_front();
          chk("write_addr_byte", {12'd0, mem_addr, mem_wd}, {12'd0, e});
        end
      end
      if (ld_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_ld_done", 32'(cyc), 32'hFFFFFFFF);
        end else begin
          int d;
          d = done_q.pop_front();
          chk("ld_done_cycle", 32'(cyc), 32'(d));
        end
      end
      if (cpu_stall && !fetch_req) chk("stall_without_req", 32'(cpu_stall), 32'd0);
    end
  end

  // This task is called just after a posedge. It presents a word and expects it to be accepted in this cycle.
  task automatic accept_word(input logic [11:0] a, input logic [31:0] d, output int acc);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    @(negedge clk);
    chk("ld_ready_accept", 32'(ld_ready), 32'd1);
    chk("stall_accept", 32'(cpu_stall), 32'd0);
    acc = cyc;
    done_q.push_back(cyc + 5);
    @(posedge clk); #1;
  endtask

  // This task checks the WRITE, GAP and return-to-IDLE cycles after acceptance. ld_valid is already low.
  task automatic follow_load(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_stall_write"}, 32'(cpu_stall), 32'(fetch_req));
      chk({tag, "_ready_write"}, 32'(ld_ready), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_gap_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_gap_addr"}, 32'(mem_addr), 32'(fetch_addr));
    chk({tag, "_gap_stall"}, 32'(cpu_stall), 32'd0);
    chk({tag, "_gap_ready"}, 32'(ld_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_idle_ready"}, 32'(ld_ready), 32'd1);
    chk({tag, "_idle_we"}, 32'(mem_we), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, found;
    reset = 1'b1; fetch_req = 1'b1; fetch_addr = 12'h0AB;
    ld_valid = 1'b1; ld_addr = 12'h100; ld_data = 32'h12345678; mem_rd = 32'h0;

    // Reset state. A pending ld_valid must not be accepted while reset is held.
    @(negedge clk);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0AB);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    reset = 1'b0;

    // Plain fetch
    fetch_req = 1'b1; fetch_addr = 12'h010; mem_rd = 32'hE3A01005;
    @(negedge clk);
    chk("fetch_data", fetch_data, 32'hE3A01005);
    chk("fetch_stall", 32'(cpu_stall), 32'd0);
    chk("fetch_we", 32'(mem_we), 32'd0);
    chk("fetch_addr", 32'(mem_addr), 32'h010);
    @(posedge clk); #1;

    // Load with fetch held. The stall is high in the 4 WRITE cycles only. Input changes after acceptance are ignored.
    push_wr(12'h020, 8'h44); push_wr(12'h021, 8'h33);
    push_wr(12'h022, 8'h22); push_wr(12'h023, 8'h11);
    accept_word(12'h020, 32'h11223344, acc1);
    ld_valid = 1'b0; ld_addr = 12'h777; ld_data = 32'hDEADBEEF;
    follow_load("ld1");
`ifdef IMEM_ARB_STALL_CNT_EN
    @(negedge clk);
    chk("stall_cycles_after_ld1", 32'(stall_cycles), 32'd4);
    @(posedge clk); #1;
`endif

    // Wrap-around load with no fetch, so the stall stays low.
    fetch_req = 1'b0;
    push_wr(12'hFFE, 8'hDD); push_wr(12'hFFF, 8'hCC);
    push_wr(12'h000, 8'hBB); push_wr(12'h001, 8'hAA);
    accept_word(12'hFFE, 32'hAABBCCDD, acc1);
    ld_valid = 1'b0;
    follow_load("wrap");

    // Back-to-back: ld_valid is held, and the second word is presented right after the first is accepted.
    fetch_req = 1'b1; fetch_addr = 12'h123;
    push_wr(12'h040, 8'h88); push_wr(12'h041, 8'h77);
    push_wr(12'h042, 8'h66); push_wr(12'h043, 8'h55);
    push_wr(12'h050, 8'hCC); push_wr(12'h051, 8'hBB);
    push_wr(12'h052, 8'hAA); push_wr(12'h053, 8'h99);
    accept_word(12'h040, 32'h55667788, acc1);
    ld_addr = 12'h050; ld_data = 32'h99AABBCC;
    found = 0; acc2 = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      @(negedge clk);
      if (cyc == acc1 + 5) chk("b2b_gap_addr", 32'(mem_addr), 32'h123);
      if (ld_ready) begin
        found = 1;
        acc2 = cyc;
        done_q.push_back(cyc + 5);
      end
      @(posedge clk); #1;
    end
    chk("b2b_second_accept_found", 32'(found), 32'd1);
    chk("b2b_spacing", 32'(acc2 - acc1), 32'd6);
    ld_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;

    // Reset after the second WRITE byte: the load aborts with no ld_done.
    push_wr(12'h080, 8'h04); push_wr(12'h081, 8'h03);
    accept_word(12'h080, 32'h01020304, acc1);
    ld_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 reset = 1'b1;
    void'(done_q.pop_back());
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_ld_done", 32'(ld_done), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'(fetch_addr));
`ifdef IMEM_ARB_STALL_CNT_EN
    chk("abort_stall_cycles", 32'(stall_cycles), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle_ready", 32'(ld_ready), 32'd1);
    chk("abort_idle_stall", 32'(cpu_stall), 32'd0);
    repeat (6) @(posedge clk);
    #1;

    chk("writes_drained", 32'(wr_q.size()), 32'd0);
    chk("dones_drained", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
